// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU constants for the fetch controller.
// State encoding and reset PC default.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MISS_WAIT  = 2'd1,
    HALT_DRAIN = 2'd2,
    HALTED     = 2'd3
  } fetch_state_t;

  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam logic [15:0] PC_STEP      = 16'h0002;
  localparam int          CNT_W        = 8;

endpackage

// File: rtl/fetch_ctrl_adder.sv
// 16-bit adder/subtractor shared by the CPU datapath.
// Wraps modulo 2^16; no carry out.
module adder_sub_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        is_sub,
  output logic [15:0] sum
);

  // add or subtract, wrap-around
  always_comb begin
    sum = is_sub ? (a - b) : (a + b);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC sequencing, branch redirect,
// I-cache miss wait, halt drain.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC     = RESET_PC_DEF,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        hazard_stall,
  input  logic        imem_stall,
  input  logic        halt_id,
  output logic [15:0] pc,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        fetch_valid,
  output logic        redirect_pending,
  output logic        halted
);

  localparam logic [CNT_W-1:0] DRAIN_LOAD =
    CNT_W'(DRAIN_CYCLES - 1);

  fetch_state_t     state;
  logic [15:0]      redir;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      pc_inc;
  logic [15:0]      pc_next;
  logic             go_drain;
  logic             go_miss;
  logic             go_run;
  logic             latch;

  adder_sub_16bit u_pc_inc (
    .a      (pc),
    .b      (PC_STEP),
    .is_sub (1'b0),
    .sum    (pc_inc)
  );

  // enables, flush and next-PC select from state and inputs
  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    fetch_valid = 1'b0;
    pc_next     = pc_inc;
    go_drain    = 1'b0;
    go_miss     = 1'b0;
    go_run      = 1'b0;
    latch       = 1'b0;
    if (rst) begin
      if_id_flush = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (hazard_stall) begin
            pc_write = 1'b0;
          end else if (halt_id) begin
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            go_drain    = 1'b1;
          end else if (branch_taken && imem_stall) begin
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            latch       = 1'b1;
            go_miss     = 1'b1;
          end else if (branch_taken) begin
            pc_write    = 1'b1;
            pc_next     = branch_target;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
          end else if (imem_stall) begin
            go_miss = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            fetch_valid = 1'b1;
          end
        end
        MISS_WAIT: begin
          if (halt_id) begin
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            go_drain    = 1'b1;
          end else if (imem_stall) begin
            latch = branch_taken;
          end else if (hazard_stall) begin
            pc_write = 1'b0;
          end else if (redirect_pending) begin
            pc_write    = 1'b1;
            pc_next     = redir;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            go_run      = 1'b1;
          end else if (branch_taken) begin
            pc_write    = 1'b1;
            pc_next     = branch_target;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            go_run      = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            fetch_valid = 1'b1;
            go_run      = 1'b1;
          end
        end
        HALT_DRAIN: begin
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
        end
        HALTED: begin
          if_id_flush = 1'b1;
        end
        default: begin
          if_id_flush = 1'b1;
        end
      endcase
    end
  end

  // state, PC, redirect register, drain counter, halted flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= RUN;
      pc               <= RESET_PC;
      redir            <= '0;
      redirect_pending <= 1'b0;
      cnt              <= '0;
      halted           <= 1'b0;
    end else begin
      if (pc_write) pc <= pc_next;
      if (latch) begin
        redir            <= branch_target;
        redirect_pending <= 1'b1;
      end
      unique case (state)
        RUN: begin
          if (go_drain) begin
            state <= HALT_DRAIN;
            cnt   <= DRAIN_LOAD;
          end else if (go_miss) begin
            state <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (go_drain) begin
            state            <= HALT_DRAIN;
            cnt              <= DRAIN_LOAD;
            redirect_pending <= 1'b0;
          end else if (go_run) begin
            state            <= RUN;
            redirect_pending <= 1'b0;
          end
        end
        HALT_DRAIN: begin
          if (cnt == '0) state <= HALTED;
          else           cnt   <= cnt - 1'b1;
        end
        HALTED: begin
          halted <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios
// plus randomized run against a behavioural model.
module tb_fetch_ctrl;

  localparam int D = 3;

  logic        clk;
  logic        rst;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        hazard_stall;
  logic        imem_stall;
  logic        halt_id;
  logic [15:0] pc;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        fetch_valid;
  logic        redirect_pending;
  logic        halted;

  int tests;
  int fails;

  fetch_ctrl #(
    .RESET_PC     (16'h0000),
    .DRAIN_CYCLES (D)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .hazard_stall     (hazard_stall),
    .imem_stall       (imem_stall),
    .halt_id          (halt_id),
    .pc               (pc),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .if_id_flush      (if_id_flush),
    .fetch_valid      (fetch_valid),
    .redirect_pending (redirect_pending),
    .halted           (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    hazard_stall  = 1'b0;
    imem_stall    = 1'b0;
    halt_id       = 1'b0;
  endtask

  task automatic go_to(input logic [15:0] a);
    idle();
    branch_taken  = 1'b1;
    branch_target = a;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 16'h1234;
    tick();
    tick();
    tests++;
    if (pc !== 16'h0000) begin
      fails++;
      $display("FAIL reset_pc: got %h expected 0000", pc);
    end
    tests++;
    if (halted !== 1'b0 || redirect_pending !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: got halted=%b pend=%b expected 0 0",
               halted, redirect_pending);
    end
    tests++;
    if ({pc_write, if_id_write, if_id_flush, fetch_valid} !== 4'b0010) begin
      fails++;
      $display("FAIL reset_enables: got %b expected 0010",
               {pc_write, if_id_write, if_id_flush, fetch_valid});
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_sequential();
    logic [15:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp = 16'(2 * i);
      #1;
      tests++;
      if (pc !== exp || fetch_valid !== 1'b1 || pc_write !== 1'b1) begin
        fails++;
        $display("FAIL seq_%0d: got pc=%h fv=%b pw=%b expected %h 1 1",
                 i, pc, fetch_valid, pc_write, exp);
      end
      tick();
    end
    go_to(16'hFFFE);
    tick();
    tests++;
    if (pc !== 16'h0000) begin
      fails++;
      $display("FAIL pc_wrap: got %h expected 0000", pc);
    end
  endtask

  task automatic test_branch();
    go_to(16'h0010);
    branch_taken  = 1'b1;
    branch_target = 16'h0040;
    #1;
    tests++;
    if (if_id_flush !== 1'b1 || fetch_valid !== 1'b0) begin
      fails++;
      $display("FAIL branch_flush: got fl=%b fv=%b expected 1 0",
               if_id_flush, fetch_valid);
    end
    tick();
    idle();
    tests++;
    if (pc !== 16'h0040) begin
      fails++;
      $display("FAIL branch_pc: got %h expected 0040", pc);
    end
  endtask

  task automatic test_miss_redirect();
    go_to(16'h0020);
    for (int i = 0; i < 5; i++) begin
      imem_stall    = 1'b1;
      branch_taken  = (i == 1);
      branch_target = 16'h0080;
      tick();
      tests++;
      if (pc !== 16'h0020) begin
        fails++;
        $display("FAIL miss_hold_%0d: got %h expected 0020", i, pc);
      end
    end
    tests++;
    if (redirect_pending !== 1'b1) begin
      fails++;
      $display("FAIL miss_pending: got %b expected 1", redirect_pending);
    end
    idle();
    #1;
    tests++;
    if (if_id_flush !== 1'b1 || fetch_valid !== 1'b0) begin
      fails++;
      $display("FAIL miss_flush: got fl=%b fv=%b expected 1 0",
               if_id_flush, fetch_valid);
    end
    tick();
    tests++;
    if (pc !== 16'h0080 || redirect_pending !== 1'b0) begin
      fails++;
      $display("FAIL miss_redirect: got pc=%h pend=%b expected 0080 0",
               pc, redirect_pending);
    end
  endtask

  task automatic test_hazard();
    go_to(16'h0030);
    hazard_stall  = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 16'h0044;
    #1;
    tests++;
    if ({pc_write, if_id_write, if_id_flush} !== 3'b000) begin
      fails++;
      $display("FAIL hazard_enables: got %b expected 000",
               {pc_write, if_id_write, if_id_flush});
    end
    tick();
    tests++;
    if (pc !== 16'h0030) begin
      fails++;
      $display("FAIL hazard_hold: got %h expected 0030", pc);
    end
    hazard_stall = 1'b0;
    tick();
    idle();
    tests++;
    if (pc !== 16'h0044) begin
      fails++;
      $display("FAIL hazard_release: got %h expected 0044", pc);
    end
  endtask

  task automatic test_halt();
    go_to(16'h0050);
    halt_id = 1'b1;
    #1;
    tests++;
    if (if_id_flush !== 1'b1 || pc_write !== 1'b0) begin
      fails++;
      $display("FAIL halt_cycle: got fl=%b pw=%b expected 1 0",
               if_id_flush, pc_write);
    end
    tick();
    idle();
    for (int k = 1; k <= 6; k++) begin
      branch_taken  = 1'(k > 4);
      branch_target = 16'h0BAD;
      imem_stall    = 1'(k == 5);
      #1;
      if (k <= D) begin
        tests++;
        if (if_id_flush !== 1'b1 || fetch_valid !== 1'b0 ||
            if_id_write !== 1'b1) begin
          fails++;
          $display("FAIL halt_drain_%0d: got fl=%b fv=%b iw=%b expected 1 0 1",
                   k, if_id_flush, fetch_valid, if_id_write);
        end
      end
      tick();
      tests++;
      if (pc !== 16'h0050 || halted !== 1'(k >= D + 1)) begin
        fails++;
        $display("FAIL halt_edge_%0d: got pc=%h halted=%b expected 0050 %b",
                 k, pc, halted, 1'(k >= D + 1));
      end
    end
    do_reset();
    tests++;
    if (pc !== 16'h0000 || halted !== 1'b0) begin
      fails++;
      $display("FAIL halt_reset: got pc=%h halted=%b expected 0000 0",
               pc, halted);
    end
  endtask

  task automatic test_random();
    logic [15:0] m_pc;
    logic [15:0] m_redir;
    logic        m_miss;
    logic        m_pend;
    int          m_ht;
    logic        r, hz, hl, br, im;
    logic [15:0] tg;
    logic [3:0]  e;
    logic [3:0]  c;
    logic [3:0]  got;
    do_reset();
    m_pc    = 16'h0000;
    m_redir = 16'h0000;
    m_miss  = 1'b0;
    m_pend  = 1'b0;
    m_ht    = -1;
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 59) == 0) || (m_ht >= D + 3);
      hz = ($urandom_range(0, 5) == 0);
      hl = ($urandom_range(0, 39) == 0);
      br = ($urandom_range(0, 3) == 0);
      im = m_miss ? ($urandom_range(0, 1) == 0)
                  : ($urandom_range(0, 3) == 0);
      tg = ($urandom_range(0, 7) == 0) ? 16'hFFFC
                                       : (16'($urandom) & 16'hFFFE);
      if (m_miss && !im) begin
        hz = 1'b0;
        br = 1'b0;
      end
      rst           = r;
      hazard_stall  = hz;
      halt_id       = hl;
      branch_taken  = br;
      imem_stall    = im;
      branch_target = tg;
      #1;
      // e/c order: pc_write, if_id_write, if_id_flush, fetch_valid
      e = 4'b0000;
      c = 4'b1111;
      if (r) begin
        e = 4'b0010;
      end else if (m_ht >= 0) begin
        e = {1'b0, 1'(m_ht < D), 2'b10};
        c = {1'b1, 1'(m_ht < D), 2'b11};
      end else if (!m_miss) begin
        if (hz) begin
          c = 4'b1110;
        end else if (hl) begin
          e = 4'b0010;
          c = 4'b1010;
        end else if (br && im) begin
          e = 4'b0010;
          c = 4'b1010;
        end else if (br) begin
          e = 4'b1110;
        end else if (im) begin
          c = 4'b1101;
        end else begin
          e = 4'b1101;
        end
      end else begin
        if (hl) begin
          e = 4'b0010;
          c = 4'b1010;
        end else if (im) begin
          c = 4'b1101;
        end else if (m_pend) begin
          e = 4'b1110;
        end else begin
          e = 4'b1101;
        end
      end
      got = {pc_write, if_id_write, if_id_flush, fetch_valid};
      tests++;
      if ((got & c) !== (e & c)) begin
        fails++;
        $display("FAIL rand_enables_%0d: got %b expected %b (mask %b)",
                 i, got, e, c);
      end
      if (r) begin
        m_pc    = 16'h0000;
        m_redir = 16'h0000;
        m_miss  = 1'b0;
        m_pend  = 1'b0;
        m_ht    = -1;
      end else if (m_ht >= 0) begin
        m_ht = m_ht + 1;
      end else if (!m_miss) begin
        if (hz) begin
          m_ht = m_ht;
        end else if (hl) begin
          m_ht = 0;
        end else if (br && im) begin
          m_redir = tg;
          m_pend  = 1'b1;
          m_miss  = 1'b1;
        end else if (br) begin
          m_pc = tg;
        end else if (im) begin
          m_miss = 1'b1;
        end else begin
          m_pc = 16'((32'(m_pc) + 2) % 65536);
        end
      end else begin
        if (hl) begin
          m_ht   = 0;
          m_miss = 1'b0;
          m_pend = 1'b0;
        end else if (im) begin
          if (br) begin
            m_redir = tg;
            m_pend  = 1'b1;
          end
        end else if (m_pend) begin
          m_pc   = m_redir;
          m_pend = 1'b0;
          m_miss = 1'b0;
        end else begin
          m_pc   = 16'((32'(m_pc) + 2) % 65536);
          m_miss = 1'b0;
        end
      end
      tick();
      tests++;
      if (pc !== m_pc || redirect_pending !== m_pend ||
          halted !== 1'(m_ht >= D + 1)) begin
        fails++;
        $display("FAIL rand_state_%0d: got pc=%h pend=%b halted=%b expected %h %b %b",
                 i, pc, redirect_pending, halted, m_pc, m_pend,
                 1'(m_ht >= D + 1));
      end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    idle();
    test_reset();
    test_sequential();
    test_branch();
    test_miss_redirect();
    test_hazard();
    test_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
